alu_sequencer: RTL

Issue/writeback stage directly upstream of the ALU. It accepts one 32-bit instruction word at a time over a valid/ready handshake and decodes it. Operands come from an internal register file. The block drives the ALU issue signals and holds them stable for the whole operation. It collects the one or two result beats (two for multiply) and writes them back to the register file.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue/writeback stage: opcodes, operand-B selects,
// instruction field positions and the sequencer FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_INC = 4'h8,
        OP_DEC = 4'h9
    } opcode_e;

    // MOVI_ZERO is never generated here; the ALU reads it as operand B = 0.
    typedef enum logic [1:0] {
        MOVI_REG  = 2'b00,
        MOVI_MEM  = 2'b01,
        MOVI_IMM  = 2'b10,
        MOVI_ZERO = 2'b11
    } movi_e;

    localparam int OP_LSB   = 28;
    localparam int MOVI_LSB = 26;
    localparam int RD_LSB   = 23;
    localparam int RA_LSB   = 20;
    localparam int RB_LSB   = 17;
    localparam int IMM_W    = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COLLECT_LO,
        S_COLLECT_HI
    } state_e;

    // 3-bit register field widened to the largest supported address width.
    function automatic logic [3:0] reg_field(input logic [31:0] instr, input int lsb);
        return {1'b0, instr[lsb +: 3]};
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake and ALU issue/result signals of the sequencer.
// slave = sequencer view, master = upstream/ALU environment view.
interface alu_sequencer_if;

    logic        in_vld;
    logic [31:0] in_instr;
    logic [31:0] in_mem;
    logic        in_rdy;

    logic        alu_act;
    logic [3:0]  alu_op;
    logic [1:0]  alu_movi;
    logic [31:0] alu_reg_a;
    logic [31:0] alu_reg_b;
    logic [31:0] alu_mem;
    logic [31:0] alu_imm;
    logic        alu_rdy;
    logic        alu_vld;
    logic [31:0] alu_data;

    modport slave (
        input  in_vld, in_instr, in_mem, alu_rdy, alu_vld, alu_data,
        output in_rdy, alu_act, alu_op, alu_movi, alu_reg_a, alu_reg_b, alu_mem, alu_imm
    );

    modport master (
        output in_vld, in_instr, in_mem, alu_rdy, alu_vld, alu_data,
        input  in_rdy, alu_act, alu_op, alu_movi, alu_reg_a, alu_reg_b, alu_mem, alu_imm
    );

endinterface

// File: rtl/alu_regfile.sv
// NREG x 32 register file: two operand read ports, one debug read port,
// one synchronous write port; R0 is hardwired to zero.
module alu_regfile #(
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   ra_data,
    output logic [31:0]   rb_data,
    output logic [31:0]   dbg_data
);

    logic [31:0] regs [NREG];

    // NOTE: the array is reset on purpose; register contents are visible on
    // the debug port and must read as zero after reset, not as power-up junk.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback stage in front of the ALU: accepts one instruction, issues
// it with stable operands, and writes back one (or two, for mul) result beats.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus,
    output logic            wb_en,
    output logic [AW-1:0]   wb_addr,
    output logic [31:0]     wb_data,
    output logic            busy,
    input  logic [AW-1:0]   dbg_addr,
    output logic [31:0]     dbg_data
);

    state_e        state, state_nxt;
    logic [31:0]   instr_q, mem_q, reg_a_q, reg_b_q;
    logic [31:0]   rf_a, rf_b;
    logic [3:0]    rd_f, ra_f, rb_f;
    logic [AW-1:0] rd, ra, rb;
    logic          is_mul;
    logic          unused_bits;

    assign rd_f   = reg_field(instr_q, RD_LSB);
    assign ra_f   = reg_field(instr_q, RA_LSB);
    assign rb_f   = reg_field(instr_q, RB_LSB);
    assign rd     = rd_f[AW-1:0];
    assign ra     = ra_f[AW-1:0];
    assign rb     = rb_f[AW-1:0];
    assign is_mul = (instr_q[OP_LSB +: 4] == OP_MUL);

    assign unused_bits = ^{instr_q[16], rd_f, ra_f, rb_f};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            instr_q <= '0;
            mem_q   <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.in_vld) begin
                instr_q <= bus.in_instr;
                mem_q   <= bus.in_mem;
            end
            if (state == S_ISSUE) begin
                reg_a_q <= rf_a;
                reg_b_q <= rf_b;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        bus.in_rdy = 1'b0;
        bus.alu_act = 1'b0;
        wb_en      = 1'b0;
        wb_addr    = '0;
        unique case (state)
            S_IDLE: begin
                bus.in_rdy = 1'b1;
                if (bus.in_vld) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.alu_rdy) begin
                    bus.alu_act = 1'b1;
                    state_nxt   = S_COLLECT_LO;
                end
            end
            S_COLLECT_LO: begin
                if (bus.alu_vld) begin
                    wb_en     = !rst;
                    wb_addr   = rd;
                    state_nxt = is_mul ? S_COLLECT_HI : S_IDLE;
                end
            end
            S_COLLECT_HI: begin
                if (bus.alu_vld) begin
                    wb_en     = !rst;
                    wb_addr   = rd + 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wb_data = wb_en ? bus.alu_data : '0;
    assign busy    = (state != S_IDLE);

    // Operands come straight from the file during ISSUE so ALU_ACT can fire
    // one cycle after acceptance; the captured copy holds them afterwards.
    assign bus.alu_reg_a = (state == S_ISSUE) ? rf_a : reg_a_q;
    assign bus.alu_reg_b = (state == S_ISSUE) ? rf_b : reg_b_q;
    assign bus.alu_op    = instr_q[OP_LSB +: 4];
    assign bus.alu_movi  = instr_q[MOVI_LSB +: 2];
    assign bus.alu_mem   = mem_q;
    assign bus.alu_imm   = {{(32-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};

    alu_regfile #(.NREG(NREG)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_en),
        .waddr    (wb_addr),
        .wdata    (wb_data),
        .ra_addr  (ra),
        .rb_addr  (rb),
        .dbg_addr (dbg_addr),
        .ra_data  (rf_a),
        .rb_data  (rf_b),
        .dbg_data (dbg_data)
    );

endmodule
